sprite_fetch_pipe: RTL
======================

# sprite_fetch_pipe

Parametrised sprite pixel fetcher for the renderer. It takes (x, y, frame) pixel requests and reads packed palette indices from an external synchronous sprite RAM, with several pixels packed per word. It returns one colour index per request through a fixed-latency valid pipeline. It generalises the single-sprite car fetcher with configurable packing, multi-frame addressing, RAM latency, out-of-bounds handling and same-word read suppression.

## Interface
Parameters:
- COLOR_W, 5, bits per palette index
- PIX_PER_WORD, 4, pixels per RAM word; power of two, ≥2
- SPRITE_W, 404, sprite width in pixels
- SPRITE_H, 96, sprite height in pixels
- FRAMES, 4, animation frames stored back-to-back
- RAM_LAT, 1, RAM read latency in cycles, ≥1
- ADDR_W, 16, RAM word-address width
- TRANSPARENT_IDX, 0, palette index treated as transparent

Derived values:
- WORD_W = COLOR_W*PIX_PER_WORD
- FRAME_WORDS = ceil(SPRITE_W*SPRITE_H/PIX_PER_WORD)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present this cycle; accepted unconditionally, no backpressure
- req_x  in  9  sprite-local x
- req_y  in  9  sprite-local y
- req_frame  in  $clog2(FRAMES)  frame select
- req_mirror  in  1  horizontal flip (see Configuration)
- ram_rd_en  out  1  RAM read strobe
- ram_addr  out  ADDR_W  RAM word address
- ram_rd_data  in  WORD_W  RAM data, valid RAM_LAT cycles after the strobe
- out_valid  out  1  result valid
- out_color  out  COLOR_W  palette index
- out_oob  out  1  request was outside the sprite
- out_transparent  out  1  out_color == TRANSPARENT_IDX

## Operation
- Request stage, combinational from the req_* inputs:
  - pixel = x + y*SPRITE_W
  - word = frame*FRAME_WORDS + (pixel >> log2(PIX_PER_WORD))
  - offset = pixel % PIX_PER_WORD
- Pixel packing order: offset 0 occupies the MSBs, i.e. bits [WORD_W-1 -: COLOR_W]. Offset k occupies bits [WORD_W-1-k*COLOR_W -: COLOR_W].
- In range means req_x < SPRITE_W and req_y < SPRITE_H. An out-of-range request issues no read and produces out_oob=1 and out_color=TRANSPARENT_IDX.
- Same-word suppression:
  - A tag register holds the word address of the most recent in-range request, with a valid bit.
  - If an in-range request's word equals the tag and the tag is valid, it is a hit: ram_rd_en stays 0 and the entry is marked reuse.
  - Otherwise ram_rd_en=1 and the tag is updated.
  - Idle cycles and OOB requests leave the tag unchanged.
- ram_rd_en = req_valid & in_range & ~hit & ~reset.
- ram_addr is driven with the word address whenever req_valid=1; otherwise it holds its previous value.
- Side-band pipeline, RAM_LAT+1 stages, carries {valid, offset, oob, reuse}.
- Output stage:
  - Source word is held_word if reuse=1, else ram_rd_data.
  - held_word is loaded from ram_rd_data on every valid, non-OOB, non-reuse entry.
  - Entries stay in order, so a reuse entry always sees the word of its originating read.
- Outputs are registered. out_color and out_oob hold their values while out_valid=0.

## Timing
- A request accepted at cycle t drives ram_addr/ram_rd_en in cycle t. Its outputs are registered at the end of cycle t+RAM_LAT and visible in cycle t+RAM_LAT+1.
- Throughput is one request per cycle with fixed latency regardless of hit or OOB status.
- Reset values: out_valid=0, out_color=0, out_oob=0, out_transparent=0, ram_addr=0. Tag valid, held_word and all pipeline valid bits are cleared.
- ram_rd_en=0 during any reset cycle.
- Reset asserted mid-stream discards every in-flight entry; out_valid=0 from the cycle after reset. A request present in the reset cycle is dropped.
- Back-to-back requests with different frames but equal pixel position never hit, because the frame is part of the word address.
- No arithmetic wrap: ADDR_W must hold FRAMES*FRAME_WORDS-1; an elaboration-time assertion enforces this.

## Configuration
- SPRITE_MIRROR_EN defined: when req_mirror=1, x is replaced by SPRITE_W-1-req_x before the pixel computation. The range check still uses the raw req_x.
- SPRITE_MIRROR_EN undefined: req_mirror is present but ignored, and no subtractor is built.

## Test plan
Defaults throughout: FRAME_WORDS=9696, RAM model with RAM_LAT=1.
- Basic fetch: req (x=5, y=0, frame 0) at cycle t -> ram_addr=1, ram_rd_en=1 at t. At t+2: out_valid=1, out_color=word1[14:10], out_oob=0.
- Hit: reqs (4,0) then (6,0) on consecutive cycles -> second has ram_rd_en=0. Outputs are word1[19:15], then word1[9:5] from held_word. An idle cycle between them still gives a hit.
- Frame and row: req (0, 1, frame 2) -> ram_addr = 19392+101 = 19493, offset 0 -> bits [19:15].
- OOB: req (404, 0) and (0, 96) -> ram_rd_en=0, out_oob=1, out_color=0, out_transparent=1 at the normal latency. The tag is unchanged, so a following (4,0) after a prior (5,0) still hits.
- Reset mid-stream: 8 back-to-back reqs, reset in cycle 3 -> out_valid=0 from cycle 4 until new requests drain. The first post-reset request misses.
- Mirror (with SPRITE_MIRROR_EN): req (0, 0, mirror=1) -> ram_addr=100, color=bits [4:0]. Without the macro, the same stimulus gives ram_addr=0, bits [19:15].

Source files
------------

// File: rtl/sprite_fetch_pipe_if.sv
// Request, sprite-RAM and result signals of sprite_fetch_pipe.
// master: requester plus RAM side; slave: the fetcher itself.
interface sprite_fetch_pipe_if #(
  parameter int unsigned COLOR_W      = 5,
  parameter int unsigned PIX_PER_WORD = 4,
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned FRAME_W      = 2
);
  localparam int unsigned WORD_W = COLOR_W * PIX_PER_WORD;

  logic               req_valid;
  logic [8:0]         req_x;
  logic [8:0]         req_y;
  logic [FRAME_W-1:0] req_frame;
  logic               req_mirror;
  logic               ram_rd_en;
  logic [ADDR_W-1:0]  ram_addr;
  logic [WORD_W-1:0]  ram_rd_data;
  logic               out_valid;
  logic [COLOR_W-1:0] out_color;
  logic               out_oob;
  logic               out_transparent;

  modport master (
    output req_valid, req_x, req_y, req_frame, req_mirror, ram_rd_data,
    input  ram_rd_en, ram_addr, out_valid, out_color, out_oob, out_transparent
  );

  modport slave (
    input  req_valid, req_x, req_y, req_frame, req_mirror, ram_rd_data,
    output ram_rd_en, ram_addr, out_valid, out_color, out_oob, out_transparent
  );
endinterface

// File: rtl/sprite_fetch_pipe.sv
// Sprite pixel fetcher: packed palette reads with same-word suppression and a fixed-latency result pipe.
// Optional feature macro: SPRITE_MIRROR_EN (horizontal flip of x on req_mirror).
module sprite_fetch_pipe #(
  parameter int unsigned COLOR_W         = 5,
  parameter int unsigned PIX_PER_WORD    = 4,
  parameter int unsigned SPRITE_W        = 404,
  parameter int unsigned SPRITE_H        = 96,
  parameter int unsigned FRAMES          = 4,
  parameter int unsigned RAM_LAT         = 1,
  parameter int unsigned ADDR_W          = 16,
  parameter int unsigned TRANSPARENT_IDX = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  sprite_fetch_pipe_if.slave   bus
);
  localparam int unsigned WORD_W      = COLOR_W * PIX_PER_WORD;
  localparam int unsigned OFF_W       = $clog2(PIX_PER_WORD);
  localparam int unsigned FRAME_WORDS = (SPRITE_W * SPRITE_H + PIX_PER_WORD - 1) / PIX_PER_WORD;

  typedef struct packed {
    logic             valid;
    logic [OFF_W-1:0] off;
    logic             oob;
    logic             reuse;
  } sb_t;

  // Elaboration-time parameter sanity.
  if (64'(FRAMES) * 64'(FRAME_WORDS) > (64'd1 << ADDR_W)) begin : g_addr_chk
    $error("sprite_fetch_pipe: ADDR_W too narrow for FRAMES*FRAME_WORDS");
  end
  if ((PIX_PER_WORD < 2) || ((PIX_PER_WORD & (PIX_PER_WORD - 1)) != 0)) begin : g_ppw_chk
    $error("sprite_fetch_pipe: PIX_PER_WORD must be a power of two >= 2");
  end
  if (RAM_LAT < 1) begin : g_lat_chk
    $error("sprite_fetch_pipe: RAM_LAT must be >= 1");
  end

`ifndef SPRITE_MIRROR_EN
  logic unused_mirror;
  assign unused_mirror = bus.req_mirror;
`endif

  logic [8:0]         x_eff;
  logic [31:0]        pixel;
  logic [31:0]        word_full;
  logic [ADDR_W-1:0]  word_addr;
  logic [OFF_W-1:0]   req_off;
  logic               in_range;
  logic               hit;
  logic               rd_en_c;
  logic [ADDR_W-1:0]  ram_addr_c;
  sb_t                sb_last;
  logic [WORD_W-1:0]  src_word;
  logic [COLOR_W-1:0] color_c;

  logic [ADDR_W-1:0]  tag_q, tag_d;
  logic               tag_valid_q, tag_valid_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [WORD_W-1:0]  held_word_q, held_word_d;
  sb_t                sb_q [RAM_LAT];
  sb_t                sb_d [RAM_LAT];
  logic               out_valid_q, out_valid_d;
  logic [COLOR_W-1:0] out_color_q, out_color_d;
  logic               out_oob_q, out_oob_d;
  logic               out_transparent_q, out_transparent_d;

  // Request stage: address, range check, tag compare.
  always_comb begin
    x_eff = bus.req_x;
`ifdef SPRITE_MIRROR_EN
    if (bus.req_mirror) x_eff = 9'(SPRITE_W - 1 - 32'(bus.req_x));
`endif
    pixel      = 32'(x_eff) + 32'(bus.req_y) * SPRITE_W;
    word_full  = 32'(bus.req_frame) * FRAME_WORDS + (pixel >> OFF_W);
    word_addr  = ADDR_W'(word_full);
    req_off    = pixel[OFF_W-1:0];
    in_range   = (32'(bus.req_x) < SPRITE_W) && (32'(bus.req_y) < SPRITE_H);
    hit        = bus.req_valid && in_range && tag_valid_q && (tag_q == word_addr);
    rd_en_c    = bus.req_valid && in_range && !hit && !reset;
    ram_addr_c = (bus.req_valid && !reset) ? word_addr : addr_q;
  end

  // Next-state for tag, side-band pipe and output stage.
  always_comb begin
    tag_d       = tag_q;
    tag_valid_d = tag_valid_q;
    addr_d      = ram_addr_c;
    held_word_d = held_word_q;
    for (int unsigned i = 0; i < RAM_LAT; i++) sb_d[i] = sb_q[i];
    out_valid_d       = 1'b0;
    out_color_d       = out_color_q;
    out_oob_d         = out_oob_q;
    out_transparent_d = out_transparent_q;

    if (rd_en_c) begin
      tag_d       = word_addr;
      tag_valid_d = 1'b1;
    end

    sb_d[0].valid = bus.req_valid;
    sb_d[0].off   = req_off;
    sb_d[0].oob   = !in_range;
    sb_d[0].reuse = hit;
    for (int unsigned i = 1; i < RAM_LAT; i++) sb_d[i] = sb_q[i-1];

    // A reuse entry reads the word latched by its originating miss.
    sb_last  = sb_q[RAM_LAT-1];
    src_word = sb_last.reuse ? held_word_q : bus.ram_rd_data;
    color_c  = COLOR_W'(src_word >> (COLOR_W * (PIX_PER_WORD - 1 - 32'(sb_last.off))));

    if (sb_last.valid && !sb_last.oob && !sb_last.reuse) held_word_d = bus.ram_rd_data;

    if (sb_last.valid) begin
      out_valid_d       = 1'b1;
      out_oob_d         = sb_last.oob;
      out_color_d       = sb_last.oob ? COLOR_W'(TRANSPARENT_IDX) : color_c;
      out_transparent_d = (out_color_d == COLOR_W'(TRANSPARENT_IDX));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q             <= '0;
      tag_valid_q       <= 1'b0;
      addr_q            <= '0;
      held_word_q       <= '0;
      for (int unsigned i = 0; i < RAM_LAT; i++) sb_q[i] <= '0;
      out_valid_q       <= 1'b0;
      out_color_q       <= '0;
      out_oob_q         <= 1'b0;
      out_transparent_q <= 1'b0;
    end else begin
      tag_q             <= tag_d;
      tag_valid_q       <= tag_valid_d;
      addr_q            <= addr_d;
      held_word_q       <= held_word_d;
      for (int unsigned i = 0; i < RAM_LAT; i++) sb_q[i] <= sb_d[i];
      out_valid_q       <= out_valid_d;
      out_color_q       <= out_color_d;
      out_oob_q         <= out_oob_d;
      out_transparent_q <= out_transparent_d;
    end
  end

  assign bus.ram_rd_en       = rd_en_c;
  assign bus.ram_addr        = ram_addr_c;
  assign bus.out_valid       = out_valid_q;
  assign bus.out_color       = out_color_q;
  assign bus.out_oob         = out_oob_q;
  assign bus.out_transparent = out_transparent_q;
endmodule
